// File: rtl/axi_ar_arbiter_if.sv
// AR-channel bundle between two read masters, the arbiter and three slaves.
// The master modport is the arbiter's view: it drives the shared slave-side AR bus.
interface axi_ar_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4
);
    logic                  ARVALID_M0;
    logic                  ARVALID_M1;
    logic [ADDR_WIDTH-1:0] ARADDR_M0;
    logic [ADDR_WIDTH-1:0] ARADDR_M1;
    logic [ID_WIDTH-1:0]   ARID_M0;
    logic [ID_WIDTH-1:0]   ARID_M1;
    logic [LEN_WIDTH-1:0]  ARLEN_M0;
    logic [LEN_WIDTH-1:0]  ARLEN_M1;
    logic                  ARREADY_M0;
    logic                  ARREADY_M1;

    logic                  ARVALID_S1;
    logic                  ARVALID_S2;
    logic                  ARVALID_SD;
    logic                  ARREADY_S1;
    logic                  ARREADY_S2;
    logic                  ARREADY_SD;
    logic [ADDR_WIDTH-1:0] ARADDR_S;
    logic [ID_WIDTH:0]     ARID_S;
    logic [LEN_WIDTH-1:0]  ARLEN_S;

    logic                  r_fire_last;
    logic [1:0]            grant;
    logic [1:0]            slave_sel;
    logic                  busy;

    modport master (
        input  ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1,
        input  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1,
        output ARREADY_M0, ARREADY_M1,
        output ARVALID_S1, ARVALID_S2, ARVALID_SD,
        input  ARREADY_S1, ARREADY_S2, ARREADY_SD,
        output ARADDR_S, ARID_S, ARLEN_S,
        input  r_fire_last,
        output grant, slave_sel, busy
    );

    modport slave (
        output ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1,
        output ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1,
        input  ARREADY_M0, ARREADY_M1,
        input  ARVALID_S1, ARVALID_S2, ARVALID_SD,
        output ARREADY_S1, ARREADY_S2, ARREADY_SD,
        input  ARADDR_S, ARID_S, ARLEN_S,
        output r_fire_last,
        input  grant, slave_sel, busy
    );
endinterface

// File: rtl/axi_ar_arbiter.sv
// Two-master round-robin AR arbiter with address decode to S1/S2/SD.
// One transaction at a time: the grant is held until the R burst's last beat.
module axi_ar_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_ar_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t                state_reg, state_next;
    logic                  ptr_reg, ptr_next;   // index of the master that wins a tie
    logic [1:0]            grant_reg, grant_next;
    logic [1:0]            sel_reg, sel_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ID_WIDTH:0]     id_reg, id_next;
    logic [LEN_WIDTH-1:0]  len_reg, len_next;

    logic                  win;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [ID_WIDTH-1:0]   win_id;
    logic [LEN_WIDTH-1:0]  win_len;
    logic [1:0]            win_sel;
    logic [2:0]            s_valid;
    logic [2:0]            s_ready;
    logic [1:0]            m_ready;
    logic                  sel_ready;

    assign s_ready = {bus.ARREADY_SD, bus.ARREADY_S2, bus.ARREADY_S1};

    for (genvar gi = 0; gi < 3; gi++) begin : g_slave
        assign s_valid[gi] = (state_reg == ADDR) && (sel_reg == 2'(gi));
    end

    // Only the selected slave's valid can be high, so this picks its ready.
    assign sel_ready = |(s_valid & s_ready);

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign m_ready[gi] = (state_reg == ADDR) && grant_reg[gi] && sel_ready;
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        sel_next   = sel_reg;
        addr_next  = addr_reg;
        id_next    = id_reg;
        len_next   = len_reg;

        win      = (bus.ARVALID_M0 && bus.ARVALID_M1) ? ptr_reg : bus.ARVALID_M1;
        win_addr = win ? bus.ARADDR_M1 : bus.ARADDR_M0;
        win_id   = win ? bus.ARID_M1   : bus.ARID_M0;
        win_len  = win ? bus.ARLEN_M1  : bus.ARLEN_M0;

        if (win_addr[31:16] == 16'h0000)
            win_sel = 2'b00;
        else if (win_addr[31:16] == 16'h0001)
            win_sel = 2'b01;
        else
            win_sel = 2'b10;

        case (state_reg)
            IDLE: begin
                if (bus.ARVALID_M0 || bus.ARVALID_M1) begin
                    state_next = ADDR;
                    grant_next = win ? 2'b10 : 2'b01;
                    sel_next   = win_sel;
                    addr_next  = win_addr;
                    id_next    = {win, win_id};
                    len_next   = win_len;
                end
            end
            ADDR: begin
                // r_fire_last is deliberately ignored here.
                if (sel_ready) begin
                    state_next = DATA;
                    ptr_next   = grant_reg[0];
                end
            end
            DATA: begin
                if (bus.r_fire_last) begin
                    state_next = IDLE;
                    grant_next = 2'b00;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            grant_reg <= 2'b00;
            sel_reg   <= 2'b00;
            addr_reg  <= '0;
            id_reg    <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            sel_reg   <= sel_next;
            addr_reg  <= addr_next;
            id_reg    <= id_next;
            len_reg   <= len_next;
        end
    end

    assign bus.ARVALID_S1 = s_valid[0];
    assign bus.ARVALID_S2 = s_valid[1];
    assign bus.ARVALID_SD = s_valid[2];
    assign bus.ARREADY_M0 = m_ready[0];
    assign bus.ARREADY_M1 = m_ready[1];
    assign bus.ARADDR_S   = addr_reg;
    assign bus.ARID_S     = id_reg;
    assign bus.ARLEN_S    = len_reg;
    assign bus.grant      = grant_reg;
    assign bus.slave_sel  = sel_reg;
    assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Bench for axi_ar_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_axi_ar_arbiter;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_ar_arbiter_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

    axi_ar_arbiter #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .bus     (bus)
    );

    logic          m_valid [2];
    logic [AW-1:0] m_addr  [2];
    logic [IW-1:0] m_id    [2];
    logic [LW-1:0] m_len   [2];
    logic          s_rdy   [3];
    logic          rfl;

    assign bus.ARVALID_M0  = m_valid[0];
    assign bus.ARVALID_M1  = m_valid[1];
    assign bus.ARADDR_M0   = m_addr[0];
    assign bus.ARADDR_M1   = m_addr[1];
    assign bus.ARID_M0     = m_id[0];
    assign bus.ARID_M1     = m_id[1];
    assign bus.ARLEN_M0    = m_len[0];
    assign bus.ARLEN_M1    = m_len[1];
    assign bus.ARREADY_S1  = s_rdy[0];
    assign bus.ARREADY_S2  = s_rdy[1];
    assign bus.ARREADY_SD  = s_rdy[2];
    assign bus.r_fire_last = rfl;

    logic [2:0] dut_sv;
    logic [1:0] dut_mr;
    assign dut_sv = {bus.ARVALID_SD, bus.ARVALID_S2, bus.ARVALID_S1};
    assign dut_mr = {bus.ARREADY_M1, bus.ARREADY_M0};

    int checks = 0;
    int errors = 0;

    // Transaction-level model: 0 = nothing owned, 1 = AR offered, 2 = burst running.
    int            md_phase;
    logic          md_owner;
    logic          md_ptr;
    int            md_sel;
    logic [AW-1:0] md_addr;
    logic [IW-1:0] md_id;
    logic [LW-1:0] md_len;
    logic          hs_m [2];
    int            data_cnt;
    int            grants_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [AW-1:0] a);
        if (a / 32'h0001_0000 == 0) return 0;
        if (a / 32'h0001_0000 == 1) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        md_phase = 0;
        md_ptr   = 1'b0;
        hs_m[0]  = 1'b0;
        hs_m[1]  = 1'b0;
    endtask

    // Compare all outputs against the model, then advance the model by one clock.
    task automatic step();
        logic [2:0] exp_sv;
        logic [1:0] exp_mr;
        logic [1:0] exp_g;
        #1;
        exp_sv = '0;
        exp_mr = '0;
        exp_g  = '0;
        if (md_phase != 0) exp_g[md_owner] = 1'b1;
        if (md_phase == 1) begin
            exp_sv[md_sel] = 1'b1;
            if (s_rdy[md_sel]) exp_mr[md_owner] = 1'b1;
        end
        check("grant", 64'(bus.grant), 64'(exp_g));
        check("busy", 64'(bus.busy), 64'(md_phase != 0));
        check("arvalid_s", 64'(dut_sv), 64'(exp_sv));
        check("arready_m", 64'(dut_mr), 64'(exp_mr));
        if (md_phase != 0) check("slave_sel", 64'(bus.slave_sel), 64'(md_sel));
        if (md_phase == 1) begin
            check("araddr_s", 64'(bus.ARADDR_S), 64'(md_addr));
            check("arid_s", 64'(bus.ARID_S), 64'({md_owner, md_id}));
            check("arlen_s", 64'(bus.ARLEN_S), 64'(md_len));
        end
        hs_m[0] = exp_mr[0];
        hs_m[1] = exp_mr[1];
        case (md_phase)
            0: if (m_valid[0] || m_valid[1]) begin
                if (m_valid[0] && m_valid[1]) md_owner = md_ptr;
                else                          md_owner = m_valid[1];
                md_addr  = m_addr[md_owner];
                md_id    = m_id[md_owner];
                md_len   = m_len[md_owner];
                md_sel   = decode(md_addr);
                md_phase = 1;
                grants_q.push_back(int'(md_owner));
            end
            1: if (s_rdy[md_sel]) begin
                md_phase = 2;
                md_ptr   = ~md_owner;
                data_cnt = int'(md_len) + int'($urandom_range(0, 2));
            end
            default: if (rfl) md_phase = 0;
        endcase
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] r;
        logic [AW-1:0] edges [5];
        edges[0] = 32'h0000_FFFF; edges[1] = 32'h0001_0000; edges[2] = 32'h0001_FFFF;
        edges[3] = 32'h0002_0000; edges[4] = 32'hFFFF_FFFF;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r = r % 32'h0001_0000;
            1: r = 32'h0001_0000 + (r % 32'h0001_0000);
            2: r = r;
            default: r = edges[$urandom_range(0, 4)];
        endcase
        return r;
    endfunction

    task automatic drive_random();
        for (int k = 0; k < 2; k++) begin
            if (hs_m[k]) m_valid[k] = 1'b0;
            if (!m_valid[k] && $urandom_range(0, 2) == 0) begin
                m_valid[k] = 1'b1;
                m_addr[k]  = rand_addr();
                m_id[k]    = IW'($urandom);
                m_len[k]   = LW'($urandom_range(0, 5));
            end
        end
        for (int s = 0; s < 3; s++) s_rdy[s] = ($urandom_range(0, 1) == 1);
        if (md_phase == 2) begin
            rfl = (data_cnt == 0);
            if (data_cnt > 0) data_cnt--;
        end else if (md_phase == 1) begin
            rfl = ($urandom_range(0, 7) == 0);
        end else begin
            rfl = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_addr[k] = '0; m_id[k] = '0; m_len[k] = '0;
        end
        for (int s = 0; s < 3; s++) s_rdy[s] = 1'b0;
        rfl = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] dec_addr [5];
        int            dec_sel  [5];
        dec_addr[0] = 32'h0000_FFFF; dec_sel[0] = 0;
        dec_addr[1] = 32'h0001_0000; dec_sel[1] = 1;
        dec_addr[2] = 32'h0001_FFFF; dec_sel[2] = 1;
        dec_addr[3] = 32'h0002_0000; dec_sel[3] = 2;
        dec_addr[4] = 32'hFFFF_FFFF; dec_sel[4] = 2;

        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_grant", 64'(bus.grant), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_arvalid", 64'(dut_sv), 64'h0);
        check("rst_araddr", 64'(bus.ARADDR_S), 64'h0);
        check("rst_arid", 64'(bus.ARID_S), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single M0 read with AR accept delayed two cycles, four-beat burst.
        m_valid[0] = 1'b1; m_addr[0] = 32'h0000_0040; m_id[0] = 4'd3; m_len[0] = 4'd3;
        step();
        #1;
        check("m0_arvalid_s1", 64'(bus.ARVALID_S1), 64'h1);
        check("m0_arid", 64'(bus.ARID_S), 64'h03);
        check("m0_arready_wait", 64'(bus.ARREADY_M0), 64'h0);
        step();
        step();
        s_rdy[0] = 1'b1;
        #1;
        check("m0_arready_pulse", 64'(bus.ARREADY_M0), 64'h1);
        step();
        m_valid[0] = 1'b0; s_rdy[0] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rfl = (b == 3);
            #1;
            check("m0_grant_burst", 64'(bus.grant), 64'h1);
            step();
        end
        rfl = 1'b0;
        #1;
        check("m0_grant_clear", 64'(bus.grant), 64'h0);

        // Decode boundaries.
        for (int i = 0; i < 5; i++) begin
            m_valid[0] = 1'b1; m_addr[0] = dec_addr[i]; m_id[0] = IW'(i);
            step();
            #1;
            check("decode_sel", 64'(bus.slave_sel), 64'(dec_sel[i]));
            check("decode_onehot", 64'(dut_sv), 64'(1 << dec_sel[i]));
            for (int s = 0; s < 3; s++) s_rdy[s] = 1'b1;
            step();
            idle_inputs();
            rfl = 1'b1;
            step();
            rfl = 1'b0;
        end

        // M1 requests while M0's burst is in DATA; then a stray completion in ADDR.
        m_valid[0] = 1'b1; m_addr[0] = 32'h0000_0100; m_len[0] = 4'd1;
        step();
        s_rdy[0] = 1'b1;
        step();
        m_valid[0] = 1'b0;
        for (int s = 0; s < 3; s++) s_rdy[s] = 1'b1;
        m_valid[1] = 1'b1; m_addr[1] = 32'h0001_0020; m_id[1] = 4'd5; m_len[1] = 4'd2;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("hold_arready_m1", 64'(bus.ARREADY_M1), 64'h0);
            check("hold_arvalid", 64'(dut_sv), 64'h0);
            step();
        end
        rfl = 1'b1;
        step();
        rfl = 1'b0;
        for (int s = 0; s < 3; s++) s_rdy[s] = 1'b0;
        #1;
        check("hold_idle_arvalid", 64'(dut_sv), 64'h0);
        step();
        #1;
        check("hold_m1_arvalid_s2", 64'(bus.ARVALID_S2), 64'h1);
        check("hold_m1_grant", 64'(bus.grant), 64'h2);
        rfl = 1'b1;
        step();
        rfl = 1'b0;
        #1;
        check("stray_arvalid_s2", 64'(bus.ARVALID_S2), 64'h1);
        check("stray_grant", 64'(bus.grant), 64'h2);
        check("stray_busy", 64'(bus.busy), 64'h1);
        s_rdy[1] = 1'b1;
        step();
        idle_inputs();

        // Asynchronous reset while M1 owns a running burst.
        #1;
        check("pre_rst_grant", 64'(bus.grant), 64'h2);
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", 64'(bus.grant), 64'h0);
        check("async_rst_busy", 64'(bus.busy), 64'h0);
        check("async_rst_arvalid", 64'(dut_sv), 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        m_valid[0] = 1'b1; m_addr[0] = 32'h0000_0010; m_id[0] = 4'd1; m_len[0] = 4'd0;
        step();
        #1;
        check("post_rst_arvalid_s1", 64'(bus.ARVALID_S1), 64'h1);
        check("post_rst_grant", 64'(bus.grant), 64'h1);
        s_rdy[0] = 1'b1;
        step();
        idle_inputs();
        rfl = 1'b1;
        step();
        idle_inputs();

        // Round-robin from reset with both masters requesting continuously.
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        grants_q.delete();
        m_valid[0] = 1'b1; m_addr[0] = 32'h0000_0200; m_id[0] = 4'd2;
        m_valid[1] = 1'b1; m_addr[1] = 32'h0003_0000; m_id[1] = 4'd9;
        for (int s = 0; s < 3; s++) s_rdy[s] = 1'b1;
        rfl = 1'b1;
        for (int c = 0; c < 12; c++) step();
        check("rr_count", 64'(grants_q.size() >= 4), 64'h1);
        for (int i = 0; i < 4; i++)
            check("rr_order", 64'((i < grants_q.size()) ? grants_q[i] : -1), 64'(i % 2));
        idle_inputs();
        step();
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_ar_arbiter.md
Name: axi_ar_arbiter

Overview:
- Read-address-channel arbiter/sequencer for the AXI interconnect.
- Shares one outstanding AR transaction between two masters: M0 (instruction fetch) and M1 (data memory).
- Decodes the winning address to slave S1 (0x0000_xxxx), S2 (0x0001_xxxx) or the default slave SD (all other addresses).
- Holds the grant until the R burst completes (RLAST handshake), and exports the routing selects used by the R-channel mux.

Parameters:
- ADDR_WIDTH, 32, address width; decode always uses addr[31:16].
- ID_WIDTH, 4, master-side ARID width; slave-side ID is ID_WIDTH+1.
- LEN_WIDTH, 4, ARLEN width.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- ARVALID_M0 / ARVALID_M1  in  1  master AR requests.
- ARADDR_M0 / ARADDR_M1  in  ADDR_WIDTH  master addresses.
- ARID_M0 / ARID_M1  in  ID_WIDTH  master IDs.
- ARLEN_M0 / ARLEN_M1  in  LEN_WIDTH  burst lengths.
- ARREADY_M0 / ARREADY_M1  out  1  AR accept to each master.
- ARVALID_S1 / ARVALID_S2 / ARVALID_SD  out  1  per-slave AR valid.
- ARREADY_S1 / ARREADY_S2 / ARREADY_SD  in  1  per-slave AR ready.
- ARADDR_S  out  ADDR_WIDTH  shared slave address.
- ARID_S  out  ID_WIDTH+1  {master index, master ARID}.
- ARLEN_S  out  LEN_WIDTH  shared burst length.
- r_fire_last  in  1  RVALID & RREADY & RLAST on the active R path.
- grant  out  2  one-hot active master [M1,M0]; 00 = none.
- slave_sel  out  2  00=S1, 01=S2, 10=SD; valid while grant != 0.
- busy  out  1  high outside IDLE.

Behaviour:
- Async reset (ARESETn low), effective immediately:
  - State = IDLE; all ARVALID_S*, ARREADY_M* = 0.
  - grant = 00, slave_sel = 00, ARADDR_S / ARID_S / ARLEN_S = 0, busy = 0.
  - Priority pointer = M0.
  - Reset mid-transaction drops the transaction silently; no completion is generated.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any ARVALID_Mx is high, select the winner by round-robin.
  - Only one valid: it wins. Both valid: the master at the priority pointer wins.
  - Register the winner's addr/id/len, grant, and slave_sel (decode of addr[31:16]: 0x0000 -> S1, 0x0001 -> S2, else SD).
  - Go to ADDR the next cycle: one-cycle request-to-ARVALID latency.
  - No ARREADY_Mx is asserted in IDLE.
- ADDR:
  - Exactly one ARVALID_S* is high, per slave_sel; outputs are driven from registers and are stable until accepted.
  - ARREADY_M(granted) = ARREADY_S(selected), combinational; the other master's ARREADY = 0.
  - On the selected slave's ARREADY & ARVALID (handshake): go to DATA, deassert ARVALID_S*, and flip the priority pointer to the non-granted master.
  - The master must hold ARVALID/ARADDR stable until its ARREADY (AXI rule). The arbiter relies only on its latched copy.
- DATA:
  - Hold grant and slave_sel. No ARVALID_S* and no ARREADY_M*.
  - On r_fire_last: go to IDLE and clear grant to 00 in the same edge.
  - A new request is arbitrated in IDLE on the following cycle, so there are at least 2 cycles from RLAST to the next ARVALID_S.
- Simultaneous events:
  - r_fire_last in ADDR is ignored; an R beat cannot precede the AR handshake.
  - Requests arriving in ADDR/DATA wait; they are never dropped.
- Decode boundaries:
  - 0x0000_FFFF -> S1; 0x0001_0000 -> S2; 0x0001_FFFF -> S2; 0x0002_0000 -> SD; 0xFFFF_FFFF -> SD.
- ARID_S[ID_WIDTH] = granted master index (0 or 1); the lower bits are the master's ARID.
- busy = (state != IDLE).

Test Plan:
- Reset values:
  - Stimulus: assert ARESETn=0 while in DATA with grant=10.
  - Response: grant=00, busy=0, all ARVALID_S*=0 immediately; after release, an M0 request 0x0000_0010 is granted normally.
- Single M0 read:
  - Stimulus: M0 ARADDR=0x0000_0040, ARID=3, ARLEN=3.
  - Response: next cycle ARVALID_S1=1, ARID_S=0_0011. ARREADY_S1 delayed 2 cycles -> ARREADY_M0 pulses with it. grant stays 01 through 4 beats, clears on the r_fire_last cycle.
- Decode:
  - Stimulus: addresses 0x0000_FFFF, 0x0001_0000, 0x0001_FFFF, 0x0002_0000, 0xFFFF_FFFF.
  - Response: slave_sel = 00, 01, 01, 10, 10; only the matching ARVALID_S* asserted.
- Round-robin:
  - Stimulus: M0 and M1 both request continuously from reset.
  - Response: grant order M0, M1, M0, M1; no master is granted twice while the other is waiting.
- Hold during DATA:
  - Stimulus: M1 raises ARVALID while M0's burst is in DATA.
  - Response: ARREADY_M1 stays 0 and no ARVALID_S* is asserted until r_fire_last. M1 is granted in the following IDLE cycle and its ARVALID_S appears 2 cycles after RLAST.
- Stray completion:
  - Stimulus: r_fire_last pulsed during ADDR with ARREADY_S2=0.
  - Response: state stays ADDR, ARVALID_S2 stays 1, grant unchanged.
